// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: per-source result FIFOs, up to 3 round-robin grants per cycle; `CDB_ARB_BYPASS_EN lets an empty FIFO's live input compete directly.
// Latency: 1 cycle with bypass, 2 cycles without (push, grant, registered bus).
// No backpressure: src_full is advisory, and a result arriving at a full FIFO is dropped and flagged in sticky overflow.
module cdb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_en,
    input  logic [5*NUM_SRC-1:0]  src_vregid,
    input  logic [32*NUM_SRC-1:0] src_val,
    output logic [NUM_SRC-1:0]    src_full,
    output logic [NUM_SRC-1:0]    overflow,
    output logic                  writeback1_en,
    output logic [4:0]            writeback1_vregid,
    output logic [31:0]           writeback1_val,
    output logic                  writeback2_en,
    output logic [4:0]            writeback2_vregid,
    output logic [31:0]           writeback2_val,
    output logic                  writeback3_en,
    output logic [4:0]            writeback3_vregid,
    output logic [31:0]           writeback3_val
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(NUM_SRC);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [IW-1:0] src_t;
    typedef logic [IW:0]   scan_t;

    typedef struct packed {
        logic [4:0]  vregid;
        logic [31:0] val;
    } res_t;

    res_t mem    [NUM_SRC][FIFO_DEPTH];
    ptr_t rd_ptr [NUM_SRC];
    ptr_t wr_ptr [NUM_SRC];
    cnt_t cnt    [NUM_SRC];
    cnt_t cnt_nxt[NUM_SRC];
    src_t rr_ptr;

    res_t live [NUM_SRC];
    res_t cand [NUM_SRC];
    logic [NUM_SRC-1:0] has_head;
    logic [NUM_SRC-1:0] cand_vld;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] drop;

    logic [2:0] slot_vld;
    src_t       slot_src [3];
    logic [1:0] ngrant;
    src_t       last_src;
    src_t       rr_nxt;
    scan_t      scan;

    logic       bus_en  [3];
    res_t       bus_res [3];

    // Candidate per source: FIFO head first so a source never overtakes its own backlog.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            live[i].vregid = src_vregid[5*i +: 5];
            live[i].val    = src_val[32*i +: 32];
            has_head[i]    = (cnt[i] != '0);
            cand[i]        = has_head[i] ? mem[i][rd_ptr[i]] : live[i];
`ifdef CDB_ARB_BYPASS_EN
            cand_vld[i]    = has_head[i] | src_en[i];
`else
            cand_vld[i]    = has_head[i];
`endif
        end
    end

    always_comb begin
        grant    = '0;
        slot_vld = '0;
        ngrant   = '0;
        last_src = rr_ptr;
        scan     = '0;
        for (int b = 0; b < 3; b++) begin
            slot_src[b] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            scan = {1'b0, rr_ptr} + scan_t'(k);
            if (scan >= scan_t'(NUM_SRC)) begin
                scan = scan - scan_t'(NUM_SRC);
            end
            if (cand_vld[scan[IW-1:0]] && (ngrant != 2'd3)) begin
                grant[scan[IW-1:0]] = 1'b1;
                slot_vld[ngrant]    = 1'b1;
                slot_src[ngrant]    = scan[IW-1:0];
                last_src            = scan[IW-1:0];
                ngrant              = ngrant + 2'd1;
            end
        end
        rr_nxt = (last_src == src_t'(NUM_SRC - 1)) ? '0 : last_src + src_t'(1);
    end

    // A bypassed grant consumes the live input, so it must not also be pushed.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]     = grant[i] & has_head[i];
            push[i]    = src_en[i] & ~(grant[i] & ~has_head[i]) &
                         ((cnt[i] < cnt_t'(FIFO_DEPTH)) | pop[i]);
            drop[i]    = src_en[i] & ~(grant[i] & ~has_head[i]) &
                         ~((cnt[i] < cnt_t'(FIFO_DEPTH)) | pop[i]);
            cnt_nxt[i] = cnt[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= live[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            src_full <= '0;
            overflow <= '0;
            rr_ptr   <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + ptr_t'(1);
                end
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + ptr_t'(1);
                end
                cnt[i]      <= cnt_nxt[i];
                src_full[i] <= (cnt_nxt[i] >= cnt_t'(FIFO_DEPTH - 1));
                if (drop[i]) begin
                    overflow[i] <= 1'b1;
                end
            end
            if (|grant) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    // Bus tag/data hold their last value while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                bus_en[b]  <= 1'b0;
                bus_res[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                bus_en[b] <= slot_vld[b];
                if (slot_vld[b]) begin
                    bus_res[b] <= cand[slot_src[b]];
                end
            end
        end
    end

    assign writeback1_en     = bus_en[0];
    assign writeback1_vregid = bus_res[0].vregid;
    assign writeback1_val    = bus_res[0].val;
    assign writeback2_en     = bus_en[1];
    assign writeback2_vregid = bus_res[1].vregid;
    assign writeback2_val    = bus_res[1].val;
    assign writeback3_en     = bus_en[2];
    assign writeback3_vregid = bus_res[2].vregid;
    assign writeback3_val    = bus_res[2].val;

endmodule
